// File: rtl/operand_collector_if.sv
// Operand A/B valid-ready channels plus the adder issue port (op_a/op_b/op_on/op_ack).
// The collector uses the slave modport; the producer/adder environment uses master.
interface operand_collector_if #(
  parameter int unsigned Width = 16
);
  logic [Width-1:0] a_in_data;
  logic             a_in_valid;
  logic             a_in_ready;
  logic [Width-1:0] b_in_data;
  logic             b_in_valid;
  logic             b_in_ready;
  logic [Width-1:0] op_a;
  logic [Width-1:0] op_b;
  logic             op_on;
  logic             op_ack;

  modport slave (
    input  a_in_data, a_in_valid, b_in_data, b_in_valid, op_ack,
    output a_in_ready, b_in_ready, op_a, op_b, op_on
  );

  modport master (
    output a_in_data, a_in_valid, b_in_data, b_in_valid, op_ack,
    input  a_in_ready, b_in_ready, op_a, op_b, op_on
  );
endinterface

// File: rtl/operand_collector.sv
// Buffers A/B operands in per-channel FIFOs and issues one pair at a time to the adder.
// Define OPERAND_COLLECTOR_ACK_TIMEOUT_EN to add a 15-cycle ack watchdog that drops stuck pairs.
module operand_collector #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 4
) (
  input  logic               clk,
  input  logic               reset,
  operand_collector_if.slave bus,
  output logic               o_done,
  output logic               o_busy,
  output logic [15:0]        o_issue_count,
  output logic               o_timeout_err
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StRelease} state_e;

  state_e           r_state;
  logic [Width-1:0] r_op_a;
  logic [Width-1:0] r_op_b;
  logic             r_op_on;
  logic             r_done;
  logic [15:0]      r_issue_count;

  logic [1:0]       w_push;
  logic [1:0]       w_ready;
  logic [1:0]       w_nonempty;
  logic             w_pop;
  logic             w_timeout;
  logic [Width-1:0] w_in_data [2];
  logic [Width-1:0] w_head [2];

  assign w_in_data[0] = bus.a_in_data;
  assign w_in_data[1] = bus.b_in_data;
  assign w_push       = {bus.b_in_valid & w_ready[1], bus.a_in_valid & w_ready[0]};
  assign w_pop        = (r_state == StIssue) && (bus.op_ack || w_timeout);

  // Ready comes from the registered count only, so a full FIFO never takes a word on a pop edge.
  for (genvar ch = 0; ch < 2; ch++) begin : g_fifo
    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr;
    logic [PtrW-1:0]  r_rd;
    logic [CntW-1:0]  r_cnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_wr  <= '0;
        r_rd  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push[ch]) r_wr <= r_wr + 1'b1;
        if (w_pop)      r_rd <= r_rd + 1'b1;
        r_cnt <= r_cnt + CntW'(w_push[ch]) - CntW'(w_pop);
      end
    end

    always_ff @(posedge clk) begin
      if (w_push[ch]) r_mem[r_wr] <= w_in_data[ch];
    end

    assign w_head[ch]     = r_mem[r_rd];
    assign w_nonempty[ch] = (r_cnt != '0);
    assign w_ready[ch]    = (r_cnt != CntW'(Depth));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= StIdle;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_op_on       <= 1'b0;
      r_done        <= 1'b0;
      r_issue_count <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_nonempty[0] && w_nonempty[1]) begin
            r_op_a  <= w_head[0];
            r_op_b  <= w_head[1];
            r_op_on <= 1'b1;
            r_state <= StIssue;
          end
        end
        StIssue: begin
          if (bus.op_ack) begin
            r_op_on       <= 1'b0;
            r_done        <= 1'b1;
            r_issue_count <= r_issue_count + 16'd1;
            r_state       <= StRelease;
          end else if (w_timeout) begin
            r_op_on <= 1'b0;
            r_state <= StRelease;
          end
        end
        // One cycle with op_on low so the adder can drop ack before the next issue.
        StRelease: r_state <= StIdle;
        default:   r_state <= StIdle;
      endcase
    end
  end

`ifdef OPERAND_COLLECTOR_ACK_TIMEOUT_EN
  logic [3:0] r_wdog;
  logic       r_timeout_err;

  // Counts ack-less ISSUE cycles; the 15th such cycle drops the pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == StIssue && !bus.op_ack) r_wdog <= r_wdog + 4'd1;
      else                                   r_wdog <= '0;
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign w_timeout     = (r_state == StIssue) && !bus.op_ack && (r_wdog == 4'd14);
  assign o_timeout_err = r_timeout_err;
`else
  assign w_timeout     = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

  assign bus.a_in_ready = w_ready[0];
  assign bus.b_in_ready = w_ready[1];
  assign bus.op_a       = r_op_a;
  assign bus.op_b       = r_op_b;
  assign bus.op_on      = r_op_on;
  assign o_done         = r_done;
  assign o_busy         = (r_state != StIdle);
  assign o_issue_count  = r_issue_count;

endmodule

// File: tb/tb_operand_collector.sv
// Directed bench for operand_collector with a simple adder model answering op_on with ack.
module tb_operand_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        done;
  logic        busy;
  logic        timeout_err;
  logic [15:0] issue_count;
  logic [15:0] add_c;
  logic        add_carry;
  logic        nack = 1'b0;
  logic [31:0] pairs_q [$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_pairs;

  always #5 clk = ~clk;

  operand_collector_if #(.Width(16)) bus ();

  operand_collector #(.Width(16), .Depth(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .o_done       (done),
    .o_busy       (busy),
    .o_issue_count(issue_count),
    .o_timeout_err(timeout_err)
  );

  // Adder: samples operands on the first op_on edge, acks one cycle later, drops ack after op_on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.op_ack <= 1'b0;
      add_c      <= '0;
      add_carry  <= 1'b0;
    end else begin
      bus.op_ack <= bus.op_on && !nack;
      if (bus.op_on && !bus.op_ack) {add_carry, add_c} <= {1'b0, bus.op_a} + {1'b0, bus.op_b};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_on(input string tag);
    int k = 0;
    while (!bus.op_on && k < 12) begin
      cyc(1);
      k++;
    end
    check(tag, 32'(bus.op_on), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 12) begin
      cyc(1);
      k++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
    bus.a_in_data  = a;
    bus.b_in_data  = b;
    bus.a_in_valid = 1'b1;
    bus.b_in_valid = 1'b1;
    cyc(1);
    bus.a_in_valid = 1'b0;
    bus.b_in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (done) begin
      pairs_q.push_back({bus.op_a, bus.op_b});
      check("op_on_low_at_done", 32'(bus.op_on), 32'd0);
    end
  end

  initial begin
    logic [15:0] ea, eb;
    reset          = 1'b1;
    bus.a_in_valid = 1'b0;
    bus.b_in_valid = 1'b0;
    bus.a_in_data  = '0;
    bus.b_in_data  = '0;
    cyc(2);
    check("rst_op_on", 32'(bus.op_on), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(issue_count), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_op_ab", {bus.op_a, bus.op_b}, 32'd0);
    reset = 1'b0;
    cyc(1);
    check("rdy_a_after_rst", 32'(bus.a_in_ready), 32'd1);
    check("rdy_b_after_rst", 32'(bus.b_in_ready), 32'd1);

    // A first, B one cycle later
    bus.a_in_data  = 16'h0003;
    bus.a_in_valid = 1'b1;
    cyc(1);
    bus.a_in_valid = 1'b0;
    bus.b_in_data  = 16'h0005;
    bus.b_in_valid = 1'b1;
    cyc(1);
    bus.b_in_valid = 1'b0;
    wait_on("p1_op_on");
    check("p1_ops", {bus.op_a, bus.op_b}, {16'h0003, 16'h0005});
    check("p1_busy", 32'(busy), 32'd1);
    wait_done("p1_done");
    check("p1_sum", {15'd0, add_carry, add_c}, 32'h0000_0008);
    check("p1_count", 32'(issue_count), 32'd1);
    cyc(1);
    check("p1_done_one_cycle", 32'(done), 32'd0);
    check("p1_pairs", 32'(pairs_q.size()), 32'd1);

    // Fill A, try a fifth A, then drain with four B words
    pairs_q.delete();
    bus.a_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.a_in_data = 16'(16'h0011 * (i + 1));
      cyc(1);
    end
    check("a_full_ready", 32'(bus.a_in_ready), 32'd0);
    check("a_only_idle", 32'(busy), 32'd0);
    bus.a_in_data = 16'h0055;
    cyc(2);
    check("a_full_hold", 32'(bus.a_in_ready), 32'd0);
    bus.a_in_valid = 1'b0;
    bus.b_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.b_in_data = 16'(16'h0101 * (i + 1));
      cyc(1);
    end
    bus.b_in_valid = 1'b0;
    cyc(20);
    check("drain_pairs", 32'(pairs_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      ea = 16'(16'h0011 * (i + 1));
      eb = 16'(16'h0101 * (i + 1));
      check("drain_order", pairs_q[i], {ea, eb});
    end
    check("drain_count", 32'(issue_count), 32'd5);
    check("drain_a_ready", 32'(bus.a_in_ready), 32'd1);

    // Carry-out pair; also shows the refused 0x0055 never entered the A FIFO
    push_pair(16'hFFFF, 16'h0001);
    wait_on("cy_op_on");
    check("cy_ops", {bus.op_a, bus.op_b}, {16'hFFFF, 16'h0001});
    wait_done("cy_done");
    check("cy_sum", {15'd0, add_carry, add_c}, 32'h0001_0000);
    check("cy_count", 32'(issue_count), 32'd6);
    cyc(1);
    check("cy_pairs", 32'(pairs_q.size()), 32'd5);

    // Reset while a pair is in ISSUE
    n_pairs = pairs_q.size();
    push_pair(16'h0007, 16'h0009);
    wait_on("mr_op_on");
    #1 reset = 1'b1;
    #1;
    check("mr_op_on_async", 32'(bus.op_on), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    check("mr_count", 32'(issue_count), 32'd0);
    check("mr_ready", {30'd0, bus.a_in_ready, bus.b_in_ready}, 32'd3);
    cyc(4);
    check("mr_flushed", 32'(bus.op_on), 32'd0);
    check("mr_no_done", 32'(pairs_q.size()), 32'(n_pairs));
    push_pair(16'h0100, 16'h0023);
    wait_on("mr2_op_on");
    check("mr2_ops", {bus.op_a, bus.op_b}, {16'h0100, 16'h0023});
    wait_done("mr2_done");
    check("mr2_sum", {15'd0, add_carry, add_c}, 32'h0000_0123);
    check("mr2_count", 32'(issue_count), 32'd1);

`ifdef OPERAND_COLLECTOR_ACK_TIMEOUT_EN
    cyc(2);
    n_pairs = pairs_q.size();
    nack = 1'b1;
    push_pair(16'h000A, 16'h000B);
    wait_on("to_op_on");
    cyc(14);
    check("to_still_issue", 32'(bus.op_on), 32'd1);
    check("to_not_yet", 32'(timeout_err), 32'd0);
    cyc(1);
    check("to_dropped", 32'(bus.op_on), 32'd0);
    check("to_flag", 32'(timeout_err), 32'd1);
    check("to_count", 32'(issue_count), 32'd1);
    check("to_no_done", 32'(pairs_q.size()), 32'(n_pairs));
    nack = 1'b0;
    cyc(2);
    push_pair(16'h000C, 16'h000D);
    wait_on("to2_op_on");
    check("to2_ops", {bus.op_a, bus.op_b}, {16'h000C, 16'h000D});
    wait_done("to2_done");
    check("to2_count", 32'(issue_count), 32'd2);
    check("to2_sticky", 32'(timeout_err), 32'd1);
`endif

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
